// File: rtl/data_memory_pkg.sv
// data_memory_pkg: shared constants and types for the data memory slice.
//
// Contents:
//   WORD_W        data word width
//   DEFAULT_DEPTH default number of words
//   RW_READ/WRITE encoding of the rw control line
//   addr_w()      index width for a given depth
//   addr_t        index type for the default depth
package data_memory_pkg;

    localparam int unsigned WORD_W        = 32;
    localparam int unsigned DEFAULT_DEPTH = 256;

    localparam logic RW_READ  = 1'b0;
    localparam logic RW_WRITE = 1'b1;

    function automatic int unsigned addr_w(input int unsigned depth);
        return $clog2(depth);
    endfunction

    typedef logic [$clog2(DEFAULT_DEPTH)-1:0] addr_t;

endpackage

// File: rtl/data_memory_array.sv
// data_memory_array: plain word storage with synchronous write and
// combinational read. The owning module registers the read data.
//
// Ports:
//   clk_i    rising-edge clock
//   clear_i  zero every word at this edge (has priority over the write)
//   we_i     write enable
//   addr_i   word address
//   wdata_i  write data
//   rdata_o  read data at addr_i
module data_memory_array
    import data_memory_pkg::*;
#(
    parameter int unsigned Depth = DEFAULT_DEPTH,
    parameter int unsigned AddrW = addr_w(Depth)
) (
    input  logic              clk_i,
    input  logic              clear_i,
    input  logic              we_i,
    input  logic [AddrW-1:0]  addr_i,
    input  logic [WORD_W-1:0] wdata_i,
    output logic [WORD_W-1:0] rdata_o
);

    logic [WORD_W-1:0] mem_q [Depth];

    always_ff @(posedge clk_i) begin
        if (clear_i) begin
            for (int i = 0; i < int'(Depth); i++) begin
                mem_q[i] <= '0;
            end
        end else if (we_i) begin
            mem_q[addr_i] <= wdata_i;
        end
    end

    assign rdata_o = mem_q[addr_i];

endmodule

// File: rtl/data_memory.sv
// data_memory: word-addressed 32-bit data memory for the memory stage.
// One read or write per clock when active; result registered on outputMem
// one cycle later. Writes are write-through to outputMem. Indices with any
// bit set at or above log2(DEPTH) are out of range: writes are dropped and
// the output becomes 0.
//
// Optional feature macro: DATA_MEMORY_RESET_CLEAR_EN
//   defined     -> reset also clears every array word
//   not defined -> reset clears only outputMem; array persists
//
// Ports:
//   clk        rising-edge clock
//   reset      synchronous active-high reset (priority over any access)
//   active     access enable
//   rw         1 = write, 0 = read
//   index      word index
//   inputMem   store data
//   outputMem  registered read / write-through data
module data_memory
    import data_memory_pkg::*;
#(
    parameter int unsigned DEPTH = DEFAULT_DEPTH
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              active,
    input  logic              rw,
    input  logic [WORD_W-1:0] index,
    output logic [WORD_W-1:0] outputMem,
    input  logic [WORD_W-1:0] inputMem
);

    localparam int unsigned AW = addr_w(DEPTH);

    logic [AW-1:0]     addr;
    logic              in_range;
    logic              we;
    logic              clear;
    logic [WORD_W-1:0] rdata;
    logic [WORD_W-1:0] out_d;
    logic [WORD_W-1:0] out_q;

    assign addr     = index[AW-1:0];
    assign in_range = ~|index[WORD_W-1:AW];
    // Reset wins over a same-cycle write, so gate it here.
    assign we       = active && (rw == RW_WRITE) && in_range && !reset;

`ifdef DATA_MEMORY_RESET_CLEAR_EN
    assign clear = reset;
`else
    assign clear = 1'b0;
`endif

    data_memory_array #(
        .Depth (DEPTH),
        .AddrW (AW)
    ) u_array (
        .clk_i   (clk),
        .clear_i (clear),
        .we_i    (we),
        .addr_i  (addr),
        .wdata_i (inputMem),
        .rdata_o (rdata)
    );

    always_comb begin
        out_d = out_q;
        if (active) begin
            if (!in_range) begin
                out_d = '0;
            end else if (rw == RW_WRITE) begin
                out_d = inputMem;
            end else begin
                out_d = rdata;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            out_q <= '0;
        end else begin
            out_q <= out_d;
        end
    end

    assign outputMem = out_q;

endmodule

// File: tb/tb_data_memory.sv
module tb_data_memory;

    logic        clk;
    logic        reset;
    logic        active;
    logic        rw;
    logic [31:0] index;
    logic [31:0] outputMem;
    logic [31:0] inputMem;

    int checks;
    int errors;

    data_memory #(
        .DEPTH (256)
    ) dut (
        .clk       (clk),
        .reset     (reset),
        .active    (active),
        .rw        (rw),
        .index     (index),
        .outputMem (outputMem),
        .inputMem  (inputMem)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Apply one cycle of stimulus, step through the edge, sample 1 time unit later.
    task automatic cycle(input logic a, input logic w, input logic [31:0] idx,
                         input logic [31:0] din);
        active   = a;
        rw       = w;
        index    = idx;
        inputMem = din;
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        reset = 1'b1;
        cycle(1'b0, 1'b0, 32'd0, 32'd0);
        cycle(1'b0, 1'b0, 32'd0, 32'd0);
        reset = 1'b0;
        checks++;
        if (outputMem !== 32'h0) begin
            errors++;
            $display("FAIL reset_out: got %h expected %h", outputMem, 32'h0);
        end
    endtask

    task automatic test_write_index1();
        cycle(1'b1, 1'b1, 32'd1, 32'd4);
        checks++;
        if (outputMem !== 32'd4) begin
            errors++;
            $display("FAIL write1_through: got %h expected %h", outputMem, 32'd4);
        end
        cycle(1'b1, 1'b0, 32'd1, 32'hFFFF_FFFF);
        checks++;
        if (outputMem !== 32'd4) begin
            errors++;
            $display("FAIL write1_readback: got %h expected %h", outputMem, 32'd4);
        end
    endtask

    task automatic test_read_back();
        cycle(1'b1, 1'b1, 32'd7, 32'hDEAD_BEEF);
        checks++;
        if (outputMem !== 32'hDEAD_BEEF) begin
            errors++;
            $display("FAIL rb_write7: got %h expected %h", outputMem, 32'hDEAD_BEEF);
        end
        cycle(1'b1, 1'b0, 32'd7, 32'd0);
        checks++;
        if (outputMem !== 32'hDEAD_BEEF) begin
            errors++;
            $display("FAIL rb_read7: got %h expected %h", outputMem, 32'hDEAD_BEEF);
        end
        cycle(1'b1, 1'b0, 32'd1, 32'd0);
        checks++;
        if (outputMem !== 32'd4) begin
            errors++;
            $display("FAIL rb_read1: got %h expected %h", outputMem, 32'd4);
        end
`ifdef DATA_MEMORY_RESET_CLEAR_EN
        cycle(1'b1, 1'b0, 32'd8, 32'd0);
        checks++;
        if (outputMem !== 32'h0) begin
            errors++;
            $display("FAIL rb_read8_cleared: got %h expected %h", outputMem, 32'h0);
        end
`endif
    endtask

    task automatic test_idle_hold();
        cycle(1'b1, 1'b0, 32'd1, 32'd0);
        checks++;
        if (outputMem !== 32'd4) begin
            errors++;
            $display("FAIL idle_pre_read: got %h expected %h", outputMem, 32'd4);
        end
        for (int i = 0; i < 2; i++) begin
            cycle(1'b0, 1'b1, 32'd1, 32'd9);
            checks++;
            if (outputMem !== 32'd4) begin
                errors++;
                $display("FAIL idle_hold[%0d]: got %h expected %h", i, outputMem, 32'd4);
            end
        end
        cycle(1'b1, 1'b0, 32'd1, 32'd0);
        checks++;
        if (outputMem !== 32'd4) begin
            errors++;
            $display("FAIL idle_mem_kept: got %h expected %h", outputMem, 32'd4);
        end
    endtask

    task automatic test_out_of_range();
        cycle(1'b1, 1'b1, 32'd0, 32'h11);
        checks++;
        if (outputMem !== 32'h11) begin
            errors++;
            $display("FAIL oor_setup0: got %h expected %h", outputMem, 32'h11);
        end
        cycle(1'b1, 1'b1, 32'd256, 32'h55);
        checks++;
        if (outputMem !== 32'h0) begin
            errors++;
            $display("FAIL oor_write256: got %h expected %h", outputMem, 32'h0);
        end
        cycle(1'b1, 1'b0, 32'd0, 32'd0);
        checks++;
        if (outputMem !== 32'h11) begin
            errors++;
            $display("FAIL oor_idx0_kept: got %h expected %h", outputMem, 32'h11);
        end
        cycle(1'b1, 1'b0, 32'h8000_0000, 32'd0);
        checks++;
        if (outputMem !== 32'h0) begin
            errors++;
            $display("FAIL oor_read_msb: got %h expected %h", outputMem, 32'h0);
        end
        cycle(1'b1, 1'b0, 32'd1, 32'd0);
        cycle(1'b1, 1'b0, 32'd257, 32'd0);
        checks++;
        if (outputMem !== 32'h0) begin
            errors++;
            $display("FAIL oor_read257: got %h expected %h", outputMem, 32'h0);
        end
    endtask

    task automatic test_reset_priority();
        cycle(1'b1, 1'b1, 32'd3, 32'h77);
        checks++;
        if (outputMem !== 32'h77) begin
            errors++;
            $display("FAIL rp_setup3: got %h expected %h", outputMem, 32'h77);
        end
        reset = 1'b1;
        cycle(1'b1, 1'b1, 32'd3, 32'h12);
        reset = 1'b0;
        checks++;
        if (outputMem !== 32'h0) begin
            errors++;
            $display("FAIL rp_out_zero: got %h expected %h", outputMem, 32'h0);
        end
        cycle(1'b1, 1'b0, 32'd3, 32'd0);
`ifdef DATA_MEMORY_RESET_CLEAR_EN
        checks++;
        if (outputMem !== 32'h0) begin
            errors++;
            $display("FAIL rp_mem3: got %h expected %h", outputMem, 32'h0);
        end
        cycle(1'b1, 1'b0, 32'd7, 32'd0);
        checks++;
        if (outputMem !== 32'h0) begin
            errors++;
            $display("FAIL rp_mem7: got %h expected %h", outputMem, 32'h0);
        end
`else
        checks++;
        if (outputMem !== 32'h77) begin
            errors++;
            $display("FAIL rp_mem3: got %h expected %h", outputMem, 32'h77);
        end
        cycle(1'b1, 1'b0, 32'd7, 32'd0);
        checks++;
        if (outputMem !== 32'hDEAD_BEEF) begin
            errors++;
            $display("FAIL rp_mem7: got %h expected %h", outputMem, 32'hDEAD_BEEF);
        end
`endif
    endtask

    task automatic test_back_to_back();
        logic        w_seq [4];
        logic [31:0] d_seq [4];
        logic [31:0] e_seq [4];
        w_seq = '{1'b1, 1'b0, 1'b1, 1'b0};
        d_seq = '{32'hA, 32'h0, 32'hB, 32'h0};
        e_seq = '{32'hA, 32'hA, 32'hB, 32'hB};
        for (int i = 0; i < 4; i++) begin
            cycle(1'b1, w_seq[i], 32'd2, d_seq[i]);
            checks++;
            if (outputMem !== e_seq[i]) begin
                errors++;
                $display("FAIL b2b[%0d]: got %h expected %h", i, outputMem, e_seq[i]);
            end
        end
    endtask

    initial begin
        checks   = 0;
        errors   = 0;
        reset    = 1'b0;
        active   = 1'b0;
        rw       = 1'b0;
        index    = '0;
        inputMem = '0;
        test_reset();
        test_write_index1();
        test_read_back();
        test_idle_hold();
        test_out_of_range();
        test_reset_priority();
        test_back_to_back();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
